// File: rtl/cpu_pkg.sv
// Shared definitions for the MEM stage slice: FSM state encoding and the
// common widths used by the stage, its memory bus and the stack pointer.
package cpu_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int STACK_STEP = 4;
    localparam int WORD_W     = 32;
    localparam int REG_W      = 5;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and memory.
//   master : the MEM stage (drives mem_req, mem_we, mem_addr, mem_wdata)
//   slave  : the data memory (drives mem_rdata, mem_ack)
interface mem_stage_if;
    import cpu_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/mem_stage_ret_stack_ptr.sv
// Hardware call/return stack pointer. The stack grows downward from
// STACK_TOP in STACK_STEP-byte words and holds at most STACK_DEPTH entries.
//   clk, rst  : clock, synchronous active-high reset
//   push, pop : commit a completed call / ret (ignored when full / empty)
//   pushAddr  : address a call writes to (SP - 4)
//   popAddr   : address a ret reads from (SP)
//   full      : depth == STACK_DEPTH
//   empty     : depth == 0
module ret_stack_ptr
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] STACK_TOP   = 32'h0000_FFFC,
    parameter int                STACK_DEPTH = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    output logic [WORD_W-1:0] pushAddr,
    output logic [WORD_W-1:0] popAddr,
    output logic              full,
    output logic              empty
);

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic [WORD_W-1:0]  sp;
    logic [DEPTH_W-1:0] depth;

    assign pushAddr = sp - WORD_W'(STACK_STEP);
    assign popAddr  = sp;
    assign full     = (depth == DEPTH_W'(STACK_DEPTH));
    assign empty    = (depth == DEPTH_W'(0));

    // Stack pointer and live-entry count; push and pop never coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp    <= STACK_TOP;
            depth <= '0;
        end else if (push && !full) begin
            sp    <= sp - WORD_W'(STACK_STEP);
            depth <= depth + DEPTH_W'(1);
        end else if (pop && !empty) begin
            sp    <= sp + WORD_W'(STACK_STEP);
            depth <= depth - DEPTH_W'(1);
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage. Takes the EX/MEM fields, runs at most one data-memory
// access over memBus, maintains the call/return stack pointer and registers
// results into MEM/WB.
//   clk, rst            : clock, synchronous active-high reset
//   *_in                : EX/MEM control and data fields
//   memBus (master)     : data-memory request/ack bus
//   stall_out           : hold EX/MEM and earlier stages
//   RegWrite_out, MemToReg_out, DestReg_out, mem_data_out, alu_data_out : MEM/WB
//   ret_valid, ret_addr : one-cycle pulse carrying a popped return address
//   err_ovf, err_unf, err_tmo : sticky stack overflow / underflow / timeout
module mem_stage
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] STACK_TOP   = 32'h0000_FFFC,
    parameter int                STACK_DEPTH = 64,
    parameter int                TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite_in,
    input  logic              MemWrite_in,
    input  logic              MemRead_in,
    input  logic              MemToReg_in,
    input  logic              MemSrc_in,
    input  logic              call_in,
    input  logic              ret_in,
    input  logic [REG_W-1:0]  DestReg_in,
    input  logic [WORD_W-1:0] ALU_addr_in,
    input  logic [WORD_W-1:0] NON_ALU_addr_in,
    input  logic [WORD_W-1:0] MemWrite_data_in,
    mem_stage_if.master       memBus,
    output logic              stall_out,
    output logic              RegWrite_out,
    output logic              MemToReg_out,
    output logic [REG_W-1:0]  DestReg_out,
    output logic [WORD_W-1:0] mem_data_out,
    output logic [WORD_W-1:0] alu_data_out,
    output logic              ret_valid,
    output logic [WORD_W-1:0] ret_addr,
    output logic              err_ovf,
    output logic              err_unf,
    output logic              err_tmo
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t            state, nextState;
    logic              isCall, isRet, isStore, isLoad;
    logic              ovfReq, unfReq, startAccess;
    logic              reqWe;
    logic [WORD_W-1:0] reqAddr, reqWdata;
    logic              ackHit, tmoHit;
    logic [TMO_W-1:0]  tmoCnt;
    logic [WORD_W-1:0] pushAddr, popAddr;
    logic              stackFull, stackEmpty;

    // Request latched at IDLE->BUSY so the bus stays stable even if upstream moves.
    logic              latWe, latCall, latRet, latRegWrite, latMemToReg;
    logic [REG_W-1:0]  latDestReg;
    logic [WORD_W-1:0] latAddr, latWdata, latAluAddr;

    ret_stack_ptr #(
        .STACK_TOP   (STACK_TOP),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_retStackPtr (
        .clk      (clk),
        .rst      (rst),
        .push     (ackHit & latCall),
        .pop      (ackHit & latRet),
        .pushAddr (pushAddr),
        .popAddr  (popAddr),
        .full     (stackFull),
        .empty    (stackEmpty)
    );

    assign memBus.mem_req   = (state == BUSY);
    assign memBus.mem_we    = (state == BUSY) & latWe;
    assign memBus.mem_addr  = (state == BUSY) ? latAddr  : '0;
    assign memBus.mem_wdata = (state == BUSY) ? latWdata : '0;

    // Prioritise call > ret > store > load; a blocked call/ret is not an access.
    always_comb begin
        isCall      = call_in;
        isRet       = ret_in & ~call_in;
        isStore     = MemWrite_in & ~call_in & ~ret_in;
        isLoad      = MemRead_in & ~MemWrite_in & ~call_in & ~ret_in;
        ovfReq      = isCall & stackFull;
        unfReq      = isRet & stackEmpty;
        startAccess = (isCall & ~stackFull) | (isRet & ~stackEmpty) | isStore | isLoad;
        reqWe       = isCall | isStore;
        reqWdata    = reqWe ? MemWrite_data_in : '0;
        reqAddr     = '0;
        if (isCall) begin
            reqAddr = pushAddr;
        end else if (isRet) begin
            reqAddr = popAddr;
        end else if (MemSrc_in) begin
            reqAddr = NON_ALU_addr_in;
        end else begin
            reqAddr = ALU_addr_in;
        end
    end

    // Next-state, stall and completion decode; ack beats a same-cycle timeout.
    always_comb begin
        nextState = state;
        stall_out = 1'b0;
        ackHit    = 1'b0;
        tmoHit    = 1'b0;
        case (state)
            IDLE: begin
                if (startAccess) begin
                    nextState = BUSY;
                    stall_out = 1'b1;
                end else begin
                    nextState = IDLE;
                    stall_out = 1'b0;
                end
            end
            BUSY: begin
                ackHit    = memBus.mem_ack;
                tmoHit    = ~memBus.mem_ack & (tmoCnt == TMO_W'(TIMEOUT - 1));
                stall_out = ~memBus.mem_ack;
                if (ackHit | tmoHit) begin
                    nextState = IDLE;
                end else begin
                    nextState = BUSY;
                end
            end
            default: begin
                nextState = IDLE;
                stall_out = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Capture the request and the fields bound for MEM/WB when an access starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            latWe       <= 1'b0;
            latCall     <= 1'b0;
            latRet      <= 1'b0;
            latRegWrite <= 1'b0;
            latMemToReg <= 1'b0;
            latDestReg  <= '0;
            latAddr     <= '0;
            latWdata    <= '0;
            latAluAddr  <= '0;
        end else if (state == IDLE && startAccess) begin
            latWe       <= reqWe;
            latCall     <= isCall;
            latRet      <= isRet;
            latRegWrite <= RegWrite_in;
            latMemToReg <= MemToReg_in;
            latDestReg  <= DestReg_in;
            latAddr     <= reqAddr;
            latWdata    <= reqWdata;
            latAluAddr  <= ALU_addr_in;
        end
    end

    // BUSY cycles without ack; held at zero in IDLE so each access starts fresh.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            tmoCnt <= '0;
        end else if (!memBus.mem_ack) begin
            tmoCnt <= tmoCnt + TMO_W'(1);
        end
    end

    // MEM/WB register, return pulse and sticky errors; held while an access waits.
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite_out <= 1'b0;
            MemToReg_out <= 1'b0;
            DestReg_out  <= '0;
            mem_data_out <= '0;
            alu_data_out <= '0;
            ret_valid    <= 1'b0;
            ret_addr     <= '0;
            err_ovf      <= 1'b0;
            err_unf      <= 1'b0;
            err_tmo      <= 1'b0;
        end else begin
            ret_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!startAccess) begin
                        RegWrite_out <= RegWrite_in;
                        MemToReg_out <= MemToReg_in;
                        DestReg_out  <= DestReg_in;
                        mem_data_out <= '0;
                        alu_data_out <= ALU_addr_in;
                        if (ovfReq) err_ovf <= 1'b1;
                        if (unfReq) err_unf <= 1'b1;
                    end
                end
                BUSY: begin
                    if (ackHit) begin
                        RegWrite_out <= latRegWrite;
                        MemToReg_out <= latMemToReg;
                        DestReg_out  <= latDestReg;
                        mem_data_out <= memBus.mem_rdata;
                        alu_data_out <= latAluAddr;
                        if (latRet) begin
                            ret_valid <= 1'b1;
                            ret_addr  <= memBus.mem_rdata;
                        end
                    end else if (tmoHit) begin
                        RegWrite_out <= 1'b0;
                        MemToReg_out <= 1'b0;
                        DestReg_out  <= '0;
                        mem_data_out <= '0;
                        alu_data_out <= '0;
                        err_tmo      <= 1'b1;
                    end
                end
                default: begin
                    ret_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
